// File: rtl/btn_pulse_gen.sv
// Debounced button-to-enable conditioner. en and pressed follow btn after DEBOUNCE_CYCLES+3 edges; no backpressure.
// Define AUTO_REPEAT_EN to add an en pulse every REPEAT_CYCLES cycles while the button stays held.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic btn,
    output logic en,
    output logic pressed
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("btn_pulse_gen: DEBOUNCE_CYCLES must be 1..255");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_bad_repeat
        $error("btn_pulse_gen: REPEAT_CYCLES must be 2..255");
    end

    state_t     state_q, state_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fire_q, fire_d;
    logic       en_q, en_d;
    logic       pressed_q, pressed_d;
    logic       btn_s;

`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] RP_LAST = 8'(REPEAT_CYCLES - 1);
    logic [7:0] rcnt_q, rcnt_d;
`endif

    assign btn_s = s2_q;

    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_d    = rcnt_q;
`endif
        // Outputs are registered from the state, giving one extra edge of latency.
        en_d      = fire_q;
        pressed_d = (state_q == HELD) || (state_q == RELEASE_WAIT);

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (rcnt_q == RP_LAST) begin
                    fire_d = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: back to HELD without a new pulse.
                    state_d = HELD;
                    cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            fire_q    <= 1'b0;
            en_q      <= 1'b0;
            pressed_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fire_q    <= fire_d;
            en_q      <= en_d;
            pressed_q <= pressed_d;
`ifdef AUTO_REPEAT_EN
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign en      = en_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed press/bounce/clear scenarios plus random button activity.
module tb_btn_pulse_gen;

    localparam int D = 4;
    localparam int R = 8;

    logic clk;
    logic clear;
    logic btn;
    logic en;
    logic pressed;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .btn    (btn),
        .en     (en),
        .pressed(pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: debounced level plus length of the current disagreeing run.
    int m_s1, m_s2, m_prev_bs;
    int m_lvl, m_run, m_hold, m_pend;
    int exp_en, exp_pressed;

    int n_pulse, n_fall, n_phigh, pressed_prev;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int exp_held(input int n);
`ifdef AUTO_REPEAT_EN
        return 1 + (n - 5) / R;
`else
        return (n > 0) ? 1 : 0;
`endif
    endfunction

    task automatic model_step(input int b, input int c);
        int bs;
        if (c != 0) begin
            m_s1 = 0; m_s2 = 0; m_prev_bs = 0;
            m_lvl = 0; m_run = 0; m_hold = 0; m_pend = 0;
            exp_en = 0; exp_pressed = 0;
        end else begin
            bs          = m_s2;
            exp_pressed = m_lvl;
            exp_en      = m_pend;
            m_pend      = 0;
            m_run       = (bs != m_lvl) ? m_run + 1 : 0;
`ifdef AUTO_REPEAT_EN
            if (m_lvl == 1 && bs == 1 && m_prev_bs == 1) begin
                m_hold++;
                if (m_hold == R) begin
                    m_pend = 1;
                    m_hold = 0;
                end
            end else begin
                m_hold = 0;
            end
`endif
            // A level change needs D+1 consecutive agreeing synchronized samples.
            if (m_run == D + 1) begin
                m_lvl  = 1 - m_lvl;
                m_run  = 0;
                m_hold = 0;
                if (m_lvl == 1) m_pend = 1;
            end
            m_prev_bs = bs;
            m_s2      = m_s1;
            m_s1      = b;
        end
    endtask

    task automatic cycle(input logic b, input logic c);
        btn   = b;
        clear = c;
        @(posedge clk);
        model_step(int'(b), int'(c));
        #1;
        chk("en", int'(en), exp_en);
        chk("pressed", int'(pressed), exp_pressed);
        if (en) n_pulse++;
        if (pressed) n_phigh++;
        if (pressed_prev == 1 && !pressed) n_fall++;
        pressed_prev = int'(pressed);
    endtask

    task automatic run_level(input logic b, input int n);
        for (int i = 0; i < n; i++) cycle(b, 1'b0);
    endtask

    initial begin
        int first;
        int len;
        logic lv;
        n_vec = 0; n_err = 0;
        n_pulse = 0; n_fall = 0; n_phigh = 0; pressed_prev = 0;
        btn = 1'b0; clear = 1'b1;

        // Reset with the button held, then first pulse 7 edges after clear drops.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("rst_en", int'(en), 0);
        chk("rst_pressed", int'(pressed), 0);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            if (en && first < 0) first = i;
        end
        chk("rst_lat", first, 7);
        run_level(1'b0, 12);

        // Clean press and release.
        n_pulse = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            if (en && first < 0) first = i;
        end
        chk("press_lat", first, 7);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            if (!pressed && first < 0) first = i;
        end
        chk("rel_lat", first, 7);
        chk("press_cnt", n_pulse, exp_held(20));

        // Bounce on press.
        n_pulse = 0;
        for (int j = 0; j < 4; j++) run_level((j % 2) == 0, 2);
        run_level(1'b1, 15);
        run_level(1'b0, 12);
        chk("bounce_press_cnt", n_pulse, exp_held(15));

        // Bounce on release.
        run_level(1'b1, 12);
        n_pulse = 0; n_fall = 0;
        cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
        run_level(1'b0, 15);
        chk("rel_bounce_en", n_pulse, 0);
        chk("rel_bounce_fall", n_fall, 1);

        // Short glitch is rejected.
        n_pulse = 0; n_phigh = 0;
        run_level(1'b1, 3);
        run_level(1'b0, 15);
        chk("glitch_en", n_pulse, 0);
        chk("glitch_pressed", n_phigh, 0);

        // Clear while held, then reacquire.
        run_level(1'b1, 12);
        cycle(1'b1, 1'b1);
        chk("clr_en", int'(en), 0);
        chk("clr_pressed", int'(pressed), 0);
        first = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            if (en && first < 0) first = i;
        end
        chk("clr_lat", first, 7);
        run_level(1'b0, 15);

        // Long hold: one pulse, or a repeat train when auto-repeat is built in.
        n_pulse = 0;
        run_level(1'b1, 40);
        run_level(1'b0, 15);
        chk("hold40_cnt", n_pulse, exp_held(40));

        // Random run lengths with occasional clear.
        lv = 1'b0;
        for (int r = 0; r < 250; r++) begin
            lv  = ~lv;
            len = int'($urandom_range(1, 14));
            for (int i = 0; i < len; i++) cycle(lv, ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
